// File: rtl/seq_muldiv_unit_if.sv
// Request/response bundle for seq_muldiv_unit: operands and opcode in,
// status pulses and the hi/lo result pair out.
interface seq_muldiv_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div0;
   logic             illegal;

   modport master (output start, op, a, b,
                   input  busy, done, hi, lo, div0, illegal);
   modport slave  (input  start, op, a, b,
                   output busy, done, hi, lo, div0, illegal);
endinterface

// File: rtl/seq_muldiv_unit.sv
// Sequential multiply/divide unit: WIDTH-cycle shift-add / restoring divide on magnitudes,
// sign fix-up in one extra cycle. Define MULDIV_MADD_EN to enable MADDU/MADD accumulate.
module seq_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_muldiv_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]      step;
   logic               op_div, neg_q, neg_r, b_zero;
`ifdef MULDIV_MADD_EN
   logic               op_acc;
`endif
   logic [WIDTH:0]     acc_hi;
   logic [WIDTH-1:0]   acc_lo, mag_b, a_raw;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               div0_q, illegal_q;

   logic               op_ok, can_start, accept, reject, last_step;
   logic               sa, sb;
   logic [WIDTH-1:0]   ma, mb;
   logic [WIDTH:0]     mul_sum, rem_sh, trial;
   logic [WIDTH-1:0]   quo, rem;
   logic [2*WIDTH-1:0] prod, res;

   always_comb begin
      op_ok = 1'b0;
      case (bus.op)
         3'd0, 3'd1, 3'd4, 3'd5: op_ok = 1'b1;
`ifdef MULDIV_MADD_EN
         3'd2, 3'd3:             op_ok = 1'b1;
`endif
         default:                op_ok = 1'b0;
      endcase
   end

   assign can_start = (state == IDLE) || (state == DONE);
   assign accept    = can_start && bus.start && op_ok;
   assign reject    = can_start && bus.start && !op_ok;
   assign last_step = (step == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (last_step) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = accept ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Odd opcodes are the signed variants; only those get magnitude conversion.
   always_comb begin
      sa = bus.op[0] & bus.a[WIDTH-1];
      sb = bus.op[0] & bus.b[WIDTH-1];
      ma = sa ? -bus.a : bus.a;
      mb = sb ? -bus.b : bus.b;
   end

   always_comb begin
      mul_sum = acc_hi + (acc_lo[0] ? {1'b0, mag_b} : '0);
      rem_sh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      trial   = rem_sh - {1'b0, mag_b};
   end

   always_comb begin
      quo  = neg_q ? -acc_lo : acc_lo;
      rem  = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
      prod = {acc_hi[WIDTH-1:0], acc_lo};
      prod = neg_q ? -prod : prod;
      if (op_div) begin
         res = b_zero ? {a_raw, {WIDTH{1'b1}}} : {rem, quo};
      end else begin
         res = prod;
`ifdef MULDIV_MADD_EN
         if (op_acc) res = prod + {hi_q, lo_q};
`endif
      end
   end

   // Multiply and divide share the accumulator pair: {acc_hi,acc_lo} shifts right
   // while multiplying and left while dividing, starting from the same load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step      <= '0;
         op_div    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         b_zero    <= 1'b0;
`ifdef MULDIV_MADD_EN
         op_acc    <= 1'b0;
`endif
         acc_hi    <= '0;
         acc_lo    <= '0;
         mag_b     <= '0;
         a_raw     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         div0_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= reject;
         if (accept) begin
            step   <= '0;
            op_div <= bus.op[2];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= (bus.b == '0);
`ifdef MULDIV_MADD_EN
            op_acc <= bus.op[1] & ~bus.op[2];
`endif
            acc_hi <= '0;
            acc_lo <= ma;
            mag_b  <= mb;
            a_raw  <= bus.a;
            div0_q <= 1'b0;
         end else if (state == CALC) begin
            step <= step + 1'b1;
            if (op_div) begin
               acc_hi <= trial[WIDTH] ? rem_sh : trial;
               acc_lo <= {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
               acc_hi <= {1'b0, mul_sum[WIDTH:1]};
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
         end else if (state == FIX) begin
            hi_q   <= res[2*WIDTH-1:WIDTH];
            lo_q   <= res[WIDTH-1:0];
            div0_q <= op_div & b_zero;
         end
      end
   end

   assign bus.busy    = (state == CALC) || (state == FIX);
   assign bus.done    = (state == DONE);
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.div0    = div0_q;
   assign bus.illegal = illegal_q;

endmodule
